sync_qualifier: RTL and testbench

Conditions the raw, asynchronous external sync input before it reaches sync_manager's sync input.
- Synchronises the input, rejects glitches and too-early pulses, and timestamps each accepted rising edge against a 64-bit free-running counter.
- Measures the period between accepted syncs and flags missing syncs with a watchdog.
- Emits a clean stretched sync level that the downstream edge detector reliably sees exactly once.

---
 rtl/sync_qual_pkg.sv | 32 +++
 rtl/sync_synchroniser.sv | 39 +++
 rtl/sync_qualifier.sv | 253 +++++++++++++++++++++++++
 tb/tb_sync_qualifier.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_qual_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_qual_pkg
//  Description : Shared types and constants for the sync qualifier. Holds
//                the qualifier FSM state encoding, timestamp and period
//                widths, and the saturating period helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_qual_pkg;

   localparam int TS_WIDTH     = 64;
   localparam int PERIOD_WIDTH = 32;

   localparam logic [PERIOD_WIDTH-1:0] PERIOD_SAT = {PERIOD_WIDTH{1'b1}};

   // Qualifier FSM encoding (2-bit, legacy-compatible constants)
   typedef logic [1:0] state_t;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_QUAL = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   // Clamp a 64-bit edge-to-edge difference into the 32-bit period field.
   function automatic logic [PERIOD_WIDTH-1:0] sat_period(input logic [TS_WIDTH-1:0] diff);
      if (diff[TS_WIDTH-1:PERIOD_WIDTH] != '0) begin
         return PERIOD_SAT;
      end
      return diff[PERIOD_WIDTH-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_synchroniser.sv
`default_nettype none
// ============================================================================
//  Module      : sync_synchroniser
//  Description : N-flop clock-domain synchroniser for a single asynchronous
//                bit. All flops clear on reset.
//  Ports       : clk      - destination clock
//                resetn   - asynchronous active-low reset
//                i_async  - raw asynchronous input
//                o_sync   - input after G_STAGES flops
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_synchroniser #(
   parameter int G_STAGES = 3
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_async,
   output logic o_sync
);

   logic [G_STAGES-1:0] chain_q;
   logic [G_STAGES-1:0] chain_d;

   always_comb begin
      chain_d = {chain_q[G_STAGES-2:0], i_async};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign o_sync = chain_q[G_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/sync_qualifier.sv
`default_nettype none
// ============================================================================
//  Module      : sync_qualifier
//  Description : Conditions a raw external sync: synchronises it, rejects
//                short and too-early pulses, timestamps accepted rising
//                edges against a 64-bit free-running counter, measures the
//                edge-to-edge period, runs a missing-sync watchdog and emits
//                a stretched clean sync level.
//  Ports       : clk, resetn (async active-low), sync_in (raw async sync),
//                i_enable, i_min_period, i_timeout (configuration),
//                o_sync (stretched sync), o_ts_valid/o_timestamp/o_period
//                (edge record), o_missing (watchdog strobe), o_locked,
//                o_sync_count/o_glitch_count (saturating event counters).
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_qualifier
   import sync_qual_pkg::*;
#(
   parameter int G_SYNC_STAGES = 3,
   parameter int G_MIN_WIDTH   = 4,
   parameter int G_OUT_WIDTH   = 4,
   parameter int G_CNT_WIDTH   = 16
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    sync_in,
   input  logic                    i_enable,
   input  logic [31:0]             i_min_period,
   input  logic [31:0]             i_timeout,
   output logic                    o_sync,
   output logic                    o_ts_valid,
   output logic [TS_WIDTH-1:0]     o_timestamp,
   output logic [PERIOD_WIDTH-1:0] o_period,
   output logic                    o_missing,
   output logic                    o_locked,
   output logic [G_CNT_WIDTH-1:0]  o_sync_count,
   output logic [G_CNT_WIDTH-1:0]  o_glitch_count
);

   localparam int                    HCNT_W  = $clog2(G_MIN_WIDTH + 1) + 1;
   localparam logic [HCNT_W-1:0]     MIN_W   = HCNT_W'(G_MIN_WIDTH);
   localparam logic [HCNT_W-1:0]     HCNT_1  = HCNT_W'(1);
   localparam int                    OCNT_W  = $clog2(G_OUT_WIDTH) + 1;
   localparam logic [OCNT_W-1:0]     OUT_REM = OCNT_W'(G_OUT_WIDTH - 1);
   localparam logic [OCNT_W-1:0]     OCNT_1  = OCNT_W'(1);
   localparam logic [G_CNT_WIDTH-1:0] CNT_1  = G_CNT_WIDTH'(1);

   logic                    s_sync;

   logic [TS_WIDTH-1:0]     free_count_q, free_count_d;
   logic [G_SYNC_STAGES-1:0] prime_q, prime_d;
   state_t                  state_q, state_d;
   logic [HCNT_W-1:0]       hcnt_q, hcnt_d;
   logic [TS_WIDTH-1:0]     ts_edge_q, ts_edge_d;
   logic [TS_WIDTH-1:0]     last_ts_q, last_ts_d;
   logic                    first_seen_q, first_seen_d;
   logic                    sync_q, sync_d;
   logic [OCNT_W-1:0]       srem_q, srem_d;
   logic                    ts_valid_q, ts_valid_d;
   logic [TS_WIDTH-1:0]     timestamp_q, timestamp_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic                    missing_q, missing_d;
   logic                    locked_q, locked_d;
   logic [G_CNT_WIDTH-1:0]  sync_cnt_q, sync_cnt_d;
   logic [G_CNT_WIDTH-1:0]  glitch_cnt_q, glitch_cnt_d;
   logic [31:0]             wd_q, wd_d;

   logic                    w_primed;
   logic [TS_WIDTH-1:0]     w_edge_ts;
   logic [TS_WIDTH-1:0]     w_diff;
   logic                    w_too_early;
   logic                    w_qualify;
   logic                    w_accept;
   logic                    w_glitch;

   sync_synchroniser #(
      .G_STAGES (G_SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .resetn  (resetn),
      .i_async (sync_in),
      .o_sync  (s_sync)
   );

   always_comb begin
      // The synchroniser comes out of reset holding zeros, which is not a real
      // low on the pin. Wait until the chain has been refilled from the pin
      // before IDLE may treat s_sync=0 as a genuine low.
      prime_d  = {prime_q[G_SYNC_STAGES-2:0], 1'b1};
      w_primed = prime_q[G_SYNC_STAGES-1];

      free_count_d = free_count_q + 64'd1;

      // In ARM the edge is the current cycle (only relevant for a
      // single-cycle minimum width); afterwards it is the captured value.
      w_edge_ts   = (state_q == ST_ARM) ? free_count_q : ts_edge_q;
      w_diff      = w_edge_ts - last_ts_q;
      w_too_early = first_seen_q && (i_min_period != 32'd0) &&
                    (w_diff < {32'd0, i_min_period});

      w_qualify = i_enable && s_sync &&
                  (((state_q == ST_ARM) && (G_MIN_WIDTH == 1)) ||
                   ((state_q == ST_QUAL) && ((hcnt_q + HCNT_1) == MIN_W)));
      w_accept  = w_qualify && !w_too_early;
      w_glitch  = (w_qualify && w_too_early) ||
                  (i_enable && (state_q == ST_QUAL) && !s_sync);

      // Qualifier FSM
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      ts_edge_d = ts_edge_q;
      if (!i_enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (w_primed && !s_sync) begin
                  state_d = ST_ARM;
               end
            end
            ST_ARM: begin
               if (s_sync) begin
                  ts_edge_d = free_count_q;
                  hcnt_d    = HCNT_1;
                  state_d   = w_qualify ? ST_HOLD : ST_QUAL;
               end
            end
            ST_QUAL: begin
               if (!s_sync) begin
                  state_d = ST_ARM;
               end else begin
                  hcnt_d = hcnt_q + HCNT_1;
                  if (w_qualify) begin
                     state_d = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (!s_sync) begin
                  state_d = ST_ARM;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Edge record
      ts_valid_d  = w_accept;
      timestamp_d = w_accept ? w_edge_ts : timestamp_q;
      period_d    = period_q;
      if (w_accept) begin
         period_d = first_seen_q ? sat_period(w_diff) : '0;
      end
      last_ts_d    = w_accept ? w_edge_ts : last_ts_q;
      first_seen_d = i_enable && (w_accept || first_seen_q);

      // Saturating counters
      sync_cnt_d = sync_cnt_q;
      if (w_accept && (sync_cnt_q != '1)) begin
         sync_cnt_d = sync_cnt_q + CNT_1;
      end
      glitch_cnt_d = glitch_cnt_q;
      if (w_glitch && (glitch_cnt_q != '1)) begin
         glitch_cnt_d = glitch_cnt_q + CNT_1;
      end

      // Output stretch; a fresh accept reloads the remaining count
      sync_d = 1'b0;
      srem_d = '0;
      if (i_enable) begin
         if (w_accept) begin
            sync_d = 1'b1;
            srem_d = OUT_REM;
         end else if (srem_q != '0) begin
            sync_d = 1'b1;
            srem_d = srem_q - OCNT_1;
         end
      end

      // Watchdog and lock; accept takes priority over an expiring watchdog
      missing_d = 1'b0;
      wd_d      = wd_q;
      locked_d  = locked_q;
      if (!i_enable) begin
         wd_d     = '0;
         locked_d = 1'b0;
      end else if (w_accept) begin
         wd_d = '0;
         if (first_seen_q) begin
            locked_d = 1'b1;
         end
      end else if (i_timeout == 32'd0) begin
         wd_d = '0;
      end else if ((wd_q + 32'd1) == i_timeout) begin
         missing_d = 1'b1;
         locked_d  = 1'b0;
         wd_d      = '0;
      end else begin
         wd_d = wd_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         free_count_q <= '0;
         prime_q      <= '0;
         state_q      <= ST_IDLE;
         hcnt_q       <= '0;
         ts_edge_q    <= '0;
         last_ts_q    <= '0;
         first_seen_q <= 1'b0;
         sync_q       <= 1'b0;
         srem_q       <= '0;
         ts_valid_q   <= 1'b0;
         timestamp_q  <= '0;
         period_q     <= '0;
         missing_q    <= 1'b0;
         locked_q     <= 1'b0;
         sync_cnt_q   <= '0;
         glitch_cnt_q <= '0;
         wd_q         <= '0;
      end else begin
         free_count_q <= free_count_d;
         prime_q      <= prime_d;
         state_q      <= state_d;
         hcnt_q       <= hcnt_d;
         ts_edge_q    <= ts_edge_d;
         last_ts_q    <= last_ts_d;
         first_seen_q <= first_seen_d;
         sync_q       <= sync_d;
         srem_q       <= srem_d;
         ts_valid_q   <= ts_valid_d;
         timestamp_q  <= timestamp_d;
         period_q     <= period_d;
         missing_q    <= missing_d;
         locked_q     <= locked_d;
         sync_cnt_q   <= sync_cnt_d;
         glitch_cnt_q <= glitch_cnt_d;
         wd_q         <= wd_d;
      end
   end

   assign o_sync         = sync_q;
   assign o_ts_valid     = ts_valid_q;
   assign o_timestamp    = timestamp_q;
   assign o_period       = period_q;
   assign o_missing      = missing_q;
   assign o_locked       = locked_q;
   assign o_sync_count   = sync_cnt_q;
   assign o_glitch_count = glitch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_qualifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sync_qualifier
//  Description : Self-checking bench for sync_qualifier. A table of pulses
//                drives the main qualification paths; hand sequences cover
//                the watchdog, enable handling and reset during qualification.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_qualifier;

   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          sync_in = 1'b0;
   logic          i_enable = 1'b0;
   logic [31:0]   i_min_period = 32'd0;
   logic [31:0]   i_timeout = 32'd0;
   logic          o_sync;
   logic          o_ts_valid;
   logic [63:0]   o_timestamp;
   logic [31:0]   o_period;
   logic          o_missing;
   logic          o_locked;
   logic [CW-1:0] o_sync_count;
   logic [CW-1:0] o_glitch_count;

   sync_qualifier dut (
      .clk            (clk),
      .resetn         (resetn),
      .sync_in        (sync_in),
      .i_enable       (i_enable),
      .i_min_period   (i_min_period),
      .i_timeout      (i_timeout),
      .o_sync         (o_sync),
      .o_ts_valid     (o_ts_valid),
      .o_timestamp    (o_timestamp),
      .o_period       (o_period),
      .o_missing      (o_missing),
      .o_locked       (o_locked),
      .o_sync_count   (o_sync_count),
      .o_glitch_count (o_glitch_count)
   );

   always #5 clk = ~clk;

   // Reference free-running count: cleared by reset, +1 per clock
   longint unsigned cyc;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   // Event monitor, sampled on the falling edge
   int              n_tsv = 0;
   int              n_miss = 0;
   int              n_runs = 0;
   int              cur_run = 0;
   int              last_run = 0;
   longint unsigned tsv_cyc = 0;
   longint unsigned tsv_ts = 0;
   longint unsigned miss_cyc = 0;
   logic [31:0]     tsv_per = 0;

   always @(negedge clk) begin
      if (o_ts_valid) begin
         n_tsv++;
         tsv_cyc = cyc;
         tsv_ts  = o_timestamp;
         tsv_per = o_period;
      end
      if (o_missing) begin
         n_miss++;
         miss_cyc = cyc;
      end
      if (o_sync) begin
         cur_run++;
      end else if (cur_run != 0) begin
         last_run = cur_run;
         n_runs++;
         cur_run = 0;
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic go_to(input longint unsigned t);
      int g = 0;
      while (cyc < t && g < 20000) begin
         @(posedge clk);
         #1;
         g++;
      end
      check("schedule", cyc, t);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      step(3);
      resetn = 1'b1;
   endtask

   typedef struct {
      int          spacing;
      int          width;
      logic [31:0] min_p;
      bit          acc;
      logic [31:0] per;
      int          glitch;
      int          scnt;
      bit          locked;
   } vec_t;

   vec_t            tbl[8];
   longint unsigned c;
   int              tsv0, runs0, miss0;

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      //           spacing width minp acc  period glitch sync locked
      tbl[0] = '{  20,   10,   0,   1,      0,    0,    1,   0 };
      tbl[1] = '{ 1000,  10,   0,   1,   1000,    0,    2,   1 };
      tbl[2] = '{ 1000,   3,   0,   0,      0,    1,    2,   1 };
      tbl[3] = '{   50,   4,   0,   1,   1050,    1,    3,   1 };
      tbl[4] = '{  200,   6, 500,   0,      0,    2,    3,   1 };
      tbl[5] = '{  800,   6, 500,   1,   1000,    2,    4,   1 };
      tbl[6] = '{  600,   1, 500,   0,      0,    3,    4,   1 };
      tbl[7] = '{  400,   5,   0,   1,   1000,    3,    5,   1 };

      // ---------------- reset state ----------------
      i_enable = 1'b1;
      do_reset();
      check("rst o_sync",      o_sync, 0);
      check("rst o_ts_valid",  o_ts_valid, 0);
      check("rst o_timestamp", o_timestamp, 0);
      check("rst o_period",    o_period, 0);
      check("rst o_missing",   o_missing, 0);
      check("rst o_locked",    o_locked, 0);
      check("rst sync_count",  o_sync_count, 0);
      check("rst glitch_cnt",  o_glitch_count, 0);

      // ---------------- table-driven pulses ----------------
      c = 0;
      for (int i = 0; i < 8; i++) begin
         c = c + longint'(tbl[i].spacing);
         i_min_period = tbl[i].min_p;
         go_to(c);
         tsv0  = n_tsv;
         runs0 = n_runs;
         sync_in = 1'b1;
         step(tbl[i].width);
         sync_in = 1'b0;
         go_to(c + longint'(tbl[i].width) + 12);
         check($sformatf("v%0d ts_valid_count", i), n_tsv - tsv0, tbl[i].acc);
         if (tbl[i].acc) begin
            // edge seen 3 cycles after the pin (synchroniser), accept 4 later
            check($sformatf("v%0d ts_valid_cycle", i), tsv_cyc, c + 7);
            check($sformatf("v%0d timestamp", i), tsv_ts, c + 3);
            check($sformatf("v%0d period", i), tsv_per, tbl[i].per);
            check($sformatf("v%0d o_sync_len", i), last_run, 4);
            check($sformatf("v%0d o_sync_runs", i), n_runs - runs0, 1);
         end else begin
            check($sformatf("v%0d o_sync_runs", i), n_runs - runs0, 0);
         end
         check($sformatf("v%0d glitch_count", i), o_glitch_count, tbl[i].glitch);
         check($sformatf("v%0d sync_count", i), o_sync_count, tbl[i].scnt);
         check($sformatf("v%0d locked", i), o_locked, tbl[i].locked);
      end

      // ---------------- watchdog ----------------
      i_min_period = 32'd0;
      i_timeout    = 32'd100;
      do_reset();
      miss0 = n_miss;
      tsv0  = n_tsv;
      go_to(350);
      check("wd missing_count", n_miss - miss0, 3);
      check("wd last_missing",  miss_cyc, 300);
      check("wd locked",        o_locked, 0);
      // qualify lands on cycle 399, the cycle the watchdog would expire
      go_to(393);
      sync_in = 1'b1;
      step(6);
      sync_in = 1'b0;
      go_to(450);
      check("wd tie ts_valid_count", n_tsv - tsv0, 1);
      check("wd tie ts_valid_cycle", tsv_cyc, 400);
      check("wd tie missing_count",  n_miss - miss0, 3);
      go_to(505);
      check("wd restart missing_count", n_miss - miss0, 4);
      check("wd restart last_missing",  miss_cyc, 500);

      // ---------------- enable with sync already high ----------------
      i_timeout = 32'd0;
      i_enable  = 1'b0;
      sync_in   = 1'b1;
      do_reset();
      step(10);
      i_enable = 1'b1;
      tsv0 = n_tsv;
      go_to(40);
      check("en high_level ts_valid_count", n_tsv - tsv0, 0);
      check("en high_level sync_count",     o_sync_count, 0);
      sync_in = 1'b0;
      go_to(45);
      c = 45;
      sync_in = 1'b1;
      go_to(c + 8);
      check("en reedge ts_valid_count", n_tsv - tsv0, 1);
      check("en reedge ts_valid_cycle", tsv_cyc, c + 7);
      check("en stretch o_sync",        o_sync, 1);
      i_enable = 1'b0;
      step(1);
      check("en drop o_sync",     o_sync, 0);
      check("en drop o_locked",   o_locked, 0);
      step(3);
      check("en drop sync_count", o_sync_count, 1);
      check("en drop timestamp",  o_timestamp, c + 3);
      sync_in = 1'b0;

      // ---------------- reset during qualification ----------------
      i_enable = 1'b1;
      do_reset();
      go_to(20);
      sync_in = 1'b1;
      step(6);
      sync_in = 1'b0;
      go_to(60);
      sync_in = 1'b1;
      go_to(64);
      check("rq pre sync_count", o_sync_count, 1);
      check("rq pre timestamp",  o_timestamp, 23);
      #2;
      resetn = 1'b0;
      #1;
      check("rq async sync_count", o_sync_count, 0);
      check("rq async timestamp",  o_timestamp, 0);
      check("rq async o_sync",     o_sync, 0);
      check("rq async ts_valid",   o_ts_valid, 0);
      check("rq async locked",     o_locked, 0);
      step(2);
      resetn = 1'b1;
      tsv0 = n_tsv;
      step(40);
      check("rq post ts_valid_count", n_tsv - tsv0, 0);
      check("rq post sync_count",     o_sync_count, 0);
      check("rq post glitch_count",   o_glitch_count, 0);
      sync_in = 1'b0;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
